// File: rtl/alu_pkg.sv
// Shared definitions for the Mini-ALU sweep controller: default widths,
// controller state encoding and the function-menu codes.
package alu_pkg;

  localparam int DEF_WIDTH   = 6;
  localparam int DEF_FXN_W   = 3;
  localparam int DEF_NUM_FXN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] FXN_A      = 3'd0;
  localparam logic [2:0] FXN_B      = 3'd1;
  localparam logic [2:0] FXN_NEG_A  = 3'd2;
  localparam logic [2:0] FXN_NEG_B  = 3'd3;
  localparam logic [2:0] FXN_A_LT_B = 3'd4;
  localparam logic [2:0] FXN_XNOR   = 3'd5;
  localparam logic [2:0] FXN_ADD    = 3'd6;
  localparam logic [2:0] FXN_SUB    = 3'd7;

endpackage

// File: rtl/alu_sweep_ctrl_res_bank.sv
// Result bank: one captured ALU result per function code, synchronous write,
// combinational read, cleared by the asynchronous reset.
module res_bank
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FXN_W   = DEF_FXN_W,
  parameter int NUM_FXN = DEF_NUM_FXN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [FXN_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [FXN_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [NUM_FXN];

  // Storage array with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FXN; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Sequencer for the Mini-ALU function menu: drives operands and function codes,
// captures each result into a bank, then streams the bank out on valid/ready.
module alu_sweep_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FXN_W   = DEF_FXN_W,
  parameter int NUM_FXN = DEF_NUM_FXN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             single,
  input  logic [FXN_W-1:0] fxn_sel,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FXN_W-1:0] alu_fxn,
  input  logic [WIDTH-1:0] alu_x,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FXN_W-1:0] res_fxn,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = FXN_W + 1;
  localparam logic [FXN_W-1:0] LAST_FXN = FXN_W'(NUM_FXN - 1);

  state_t             state_r, state_s;
  logic               mode_r, mode_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [FXN_W-1:0]   rd_idx_r, rd_idx_s;
  logic [WIDTH-1:0]   alu_a_s, alu_b_s, res_data_s, bank_rdata_s, rd_data_s;
  logic [FXN_W-1:0]   alu_fxn_s, res_fxn_s;
  logic               res_valid_s, busy_s, done_s, we_s, load_res_s;

  res_bank #(.WIDTH(WIDTH), .FXN_W(FXN_W), .NUM_FXN(NUM_FXN)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (alu_fxn),
    .wdata (alu_x),
    .raddr (rd_idx_s),
    .rdata (bank_rdata_s)
  );

  // Next-state, capture and handshake decisions.
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    cnt_s       = cnt_r;
    rd_idx_s    = rd_idx_r;
    alu_a_s     = alu_a;
    alu_b_s     = alu_b;
    alu_fxn_s   = alu_fxn;
    res_valid_s = res_valid;
    done_s      = 1'b0;
    we_s        = 1'b0;
    load_res_s  = 1'b0;
    case (state_r)
      IDLE: begin
        res_valid_s = 1'b0;
        if (start) begin
          alu_a_s   = a_in;
          alu_b_s   = b_in;
          mode_s    = single;
          alu_fxn_s = single ? fxn_sel : {FXN_W{1'b0}};
          rd_idx_s  = single ? fxn_sel : {FXN_W{1'b0}};
          cnt_s     = single ? CNT_W'(1) : CNT_W'(NUM_FXN);
          state_s   = SWEEP;
        end else begin
          state_s = IDLE;
        end
      end
      SWEEP: begin
        we_s = 1'b1;
        if (mode_r || (alu_fxn == LAST_FXN)) begin
          state_s     = DRAIN;
          res_valid_s = 1'b1;
          load_res_s  = 1'b1;
        end else begin
          state_s = SWEEP;
        end
        if (mode_r) begin
          alu_fxn_s = alu_fxn;
        end else begin
          alu_fxn_s = alu_fxn + FXN_W'(1);
        end
      end
      DRAIN: begin
        res_valid_s = 1'b1;
        if (res_ready) begin
          cnt_s    = cnt_r - CNT_W'(1);
          rd_idx_s = rd_idx_r + FXN_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_s     = IDLE;
            res_valid_s = 1'b0;
            done_s      = 1'b1;
          end else begin
            load_res_s = 1'b1;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s     = IDLE;
        res_valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // Presented result; bypass covers the single-mode entry edge, where the
  // entry being read is being written in the same cycle.
  always_comb begin
    rd_data_s = bank_rdata_s;
    if (we_s && (alu_fxn == rd_idx_s)) begin
      rd_data_s = alu_x;
    end else begin
      rd_data_s = bank_rdata_s;
    end
    if (load_res_s) begin
      res_fxn_s  = rd_idx_s;
      res_data_s = rd_data_s;
    end else begin
      res_fxn_s  = res_fxn;
      res_data_s = res_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mode_r    <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      rd_idx_r  <= {FXN_W{1'b0}};
      alu_a     <= {WIDTH{1'b0}};
      alu_b     <= {WIDTH{1'b0}};
      alu_fxn   <= {FXN_W{1'b0}};
      res_valid <= 1'b0;
      res_fxn   <= {FXN_W{1'b0}};
      res_data  <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      mode_r    <= mode_s;
      cnt_r     <= cnt_s;
      rd_idx_r  <= rd_idx_s;
      alu_a     <= alu_a_s;
      alu_b     <= alu_b_s;
      alu_fxn   <= alu_fxn_s;
      res_valid <= res_valid_s;
      res_fxn   <= res_fxn_s;
      res_data  <= res_data_s;
      busy      <= busy_s;
      done      <= done_s;
    end
  end

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Directed bench for alu_sweep_ctrl with a behavioural Mini-ALU datapath
// closing the alu_a/alu_b/alu_fxn -> alu_x loop.
module tb_alu_sweep_ctrl;
  import alu_pkg::*;

  localparam int W = 6;
  localparam int F = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         single = 1'b0;
  logic         res_ready = 1'b0;
  logic [F-1:0] fxn_sel = 3'd0;
  logic [W-1:0] a_in = 6'd0;
  logic [W-1:0] b_in = 6'd0;
  logic [W-1:0] alu_a, alu_b, alu_x, res_data;
  logic [F-1:0] alu_fxn, res_fxn;
  logic         res_valid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .single(single), .fxn_sel(fxn_sel),
    .a_in(a_in), .b_in(b_in), .alu_a(alu_a), .alu_b(alu_b), .alu_fxn(alu_fxn),
    .alu_x(alu_x), .res_valid(res_valid), .res_ready(res_ready), .res_fxn(res_fxn),
    .res_data(res_data), .busy(busy), .done(done)
  );

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [F-1:0] f);
    case (f)
      FXN_A:      return a;
      FXN_B:      return b;
      FXN_NEG_A:  return 6'd0 - a;
      FXN_NEG_B:  return 6'd0 - b;
      FXN_A_LT_B: return (a < b) ? 6'd1 : 6'd0;
      FXN_XNOR:   return ~(a ^ b);
      FXN_ADD:    return a + b;
      FXN_SUB:    return a - b;
      default:    return 6'd0;
    endcase
  endfunction

  assign alu_x = alu_model(alu_a, alu_b, alu_fxn);

  typedef struct packed {
    logic [5:0]      a;
    logic [5:0]      b;
    logic            single;
    logic [2:0]      sel;
    logic [7:0][5:0] exp;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input logic [5:0] a, input logic [5:0] b, input logic s,
                              input logic [2:0] sel, input logic [5:0] e0, input logic [5:0] e1,
                              input logic [5:0] e2, input logic [5:0] e3, input logic [5:0] e4,
                              input logic [5:0] e5, input logic [5:0] e6, input logic [5:0] e7);
    vec_t v;
    v.a = a; v.b = b; v.single = s; v.sel = sel;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp[4] = e4; v.exp[5] = e5; v.exp[6] = e6; v.exp[7] = e7;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Starts one transaction at the current negedge and drains it; returns at the
  // negedge of the done cycle. rmode 1 applies the 1,0,0 ready pattern; noise
  // keeps start high with other operands while busy.
  task automatic run_vec(input vec_t v, input int rmode, input bit noise);
    int n, k, idx, cyc;
    logic [2:0] ef;
    n = v.single ? 1 : 8;
    start = 1'b1; single = v.single; fxn_sel = v.sel; a_in = v.a; b_in = v.b;
    @(posedge clk);
    @(negedge clk);
    start = noise;
    if (noise) begin
      a_in = 6'd1; b_in = 6'd1; single = 1'b1;
    end
    check("busy_after_start", busy, 1);
    k = 0;
    while (!res_valid && k < 20) begin
      check("operand_a_stable", alu_a, v.a);
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("first_valid_latency", k, v.single ? 1 : 8);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 100) begin
      res_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      ef = v.single ? v.sel : idx[2:0];
      check("res_valid", res_valid, 1);
      check("res_fxn", res_fxn, ef);
      check("res_data", res_data, v.exp[idx]);
      check("operand_b_stable", alu_b, v.b);
      if (res_ready) idx++;
      if (noise) start = !(res_ready && idx == n);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    res_ready = 1'b0;
    start = 1'b0;
    check("result_count", idx, n);
    check("done_pulse", done, 1);
    check("valid_low_in_done", res_valid, 0);
    check("busy_low_in_done", busy, 0);
  endtask

  task automatic idle_check();
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, k;
    vecs[0] = mk(6'd5,  6'd3,  1'b0, 3'd0, 6'd5,  6'd3,  6'd59, 6'd61, 6'd0, 6'd57, 6'd8,  6'd2);
    vecs[1] = mk(6'd2,  6'd9,  1'b1, 3'd4, 6'd1,  6'd0,  6'd0,  6'd0,  6'd0, 6'd0,  6'd0,  6'd0);
    vecs[2] = mk(6'd63, 6'd0,  1'b0, 3'd0, 6'd63, 6'd0,  6'd1,  6'd0,  6'd0, 6'd0,  6'd63, 6'd63);
    vecs[3] = mk(6'd10, 6'd20, 1'b0, 3'd0, 6'd10, 6'd20, 6'd54, 6'd44, 6'd1, 6'd33, 6'd30, 6'd54);
    vecs[4] = mk(6'd33, 6'd12, 1'b1, 3'd5, 6'd18, 6'd0,  6'd0,  6'd0,  6'd0, 6'd0,  6'd0,  6'd0);

    #12;
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_fxn", alu_fxn, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_fxn", res_fxn, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], 0, 1'b0);
      idle_check();
    end

    run_vec(vecs[0], 1, 1'b0);
    idle_check();
    run_vec(vecs[1], 1, 1'b0);
    idle_check();

    run_vec(vecs[0], 0, 1'b1);
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("no_extra_activity_after_start_noise", cnt, 0);

    // Reset in the middle of draining.
    start = 1'b1; single = 1'b0; a_in = 6'd5; b_in = 6'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!res_valid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    res_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_drain_fxn", res_fxn, 3);
    check("mid_drain_data", res_data, 61);
    res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_res_valid", res_valid, 0);
    check("arst_res_fxn", res_fxn, 0);
    check("arst_res_data", res_data, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_b", alu_b, 0);
    check("arst_alu_fxn", alu_fxn, 0);
    check("arst_busy", busy, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    res_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid || done) cnt++;
    end
    res_ready = 1'b0;
    check("no_output_after_reset", cnt, 0);
    run_vec(vecs[0], 0, 1'b0);
    idle_check();

    // Back-to-back: the second start is driven in the done cycle.
    run_vec(vecs[0], 0, 1'b0);
    run_vec(vecs[2], 0, 1'b0);
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
